mcash_axi3_mem_slave: RTL
=========================

Name: mcash_axi3_mem_slave

Overview:
- Behavioural-synthesizable AXI3 slave memory attached to one mcash bank BIU port (bank0..bank3). It is the stage directly downstream of mcash_top.
- Consumes AR/AW/W and produces R/B, so bank refills and write-backs complete in simulation.
- One instance per bank. Each instance owns a private 256-bit-wide memory array.

Parameters:
- MEM_AW, 10, log2 of memory depth in 256-bit lines. Line index = addr[MEM_AW+4:5]; higher address bits are ignored, so addresses alias modulo depth.
- READ_LATENCY, 4, cycles from AR handshake edge to first rvalid (legal range 1..15).
- WRESP_LATENCY, 2, cycles from wlast handshake edge to bvalid (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- arvalid in 1; arready out 1; arid in 8; araddr in 32; arsize in 3; arlen in 4; arburst in 2 — read address channel
- rvalid out 1; rready in 1; rid out 8; rdata out 256; rresp out 2; rlast out 1 — read data channel
- awvalid in 1; awready out 1; awaddr in 32; awlen in 4; awsize in 3; awburst in 2 — write address channel
- wid in 8; wvalid in 1; wready out 1; wdata in 256; wstrb in 32; wlast in 1 — write data channel
- bvalid out 1; bready in 1; bid out 8; bresp out 2 — write response channel

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high, all outputs are 0 and both FSMs are forced to IDLE. This applies to a reset mid-burst as well.
  - The memory array is NOT reset; contents are retained.
  - arready/awready are registered and rise on the first clk edge after rst deasserts.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch id, line, len and burst, and set err = (arsize!=3'd5) | (arburst==2'b11). Load lat_cnt=READ_LATENCY-1, drop arready, and go to R_WAIT.
  - R_WAIT: decrement lat_cnt. At 0, register beat 0 (rdata, rresp, rlast = (len==0)), assert rvalid, and go to R_DATA.
  - R_DATA: rvalid, rdata, rid, rresp and rlast are held stable while rready=0.
    - On rvalid&rready with beat!=len: register the next beat in the same edge (back-to-back, no bubble).
    - On rvalid&rready with beat==len: drop rvalid, raise arready, go to R_IDLE.
  - Beat addressing: INCR and WRAP use line+beat, wrapping modulo depth. FIXED (00) repeats the same line.
  - Error beats: rdata=0, rresp=2'b10 (SLVERR). Otherwise rresp=2'b00.
  - rid = latched arid.
- Write FSM, states W_IDLE, W_DATA, W_WAIT, W_RESP:
  - W_IDLE: awready=1. On the handshake, latch addr/len/burst, set beat=0, drop awready, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata byte lanes where wstrb[i]=1 to the current line; beat increments.
    - bid is latched from wid on beat 0.
    - Error flag is set if any beat has wid != bid, or if the wlast position != len.
    - On wlast handshake: load lat_cnt=WRESP_LATENCY-1 and go to W_WAIT.
    - Beats beyond len+1 without wlast are written to line+beat and flag the error.
  - W_WAIT: count down to 0, then assert bvalid with bresp = err ? 2'b10 : 2'b00, and go to W_RESP.
  - W_RESP: hold until bready, then deassert bvalid, raise awready, go to W_IDLE.
  - awsize!=5 is treated as SLVERR. The data is still written.
- Concurrency: the read and write FSMs are independent.
  - When a read beat register and a write to the same line occur on the same edge, rdata returns the OLD contents.
- Only one outstanding transaction per direction. The next AR/AW is accepted only in IDLE.

Test Plan:
- After reset, AW addr=0x40 len=1, two beats of 0xA5.. with strb=all ones, wid=3 -> bvalid 2 cycles after wlast, bid=3, bresp=0. Then AR addr=0x40 len=1 id=7 -> first rvalid exactly 4 cycles after AR handshake, two beats of 0xA5.., rid=7, rlast on beat 1.
- Partial write: strb=0x0000000F, data=0x11223344 onto line of 0xFF..FF -> readback shows the low 4 bytes =0x11223344 and the rest 0xFF.
- Read with rready toggling 1,0,0,1 over a len=3 burst -> data held stable while stalled; exactly 4 beats; rlast only on the 4th.
- arsize=3'd4 -> all beats have rresp=2'b10 and rdata=0; FSM returns to R_IDLE with arready=1.
- Write with wlast on beat 0 while awlen=1 -> bresp=2'b10. Simultaneous read of line 5 while line 5 is being written -> old data returned.
- Assert rst mid read burst at beat 1 of 3 -> rvalid=0 and arready=0 immediately; arready=1 one edge after release. Memory retains previously written 0xA5.. at 0x40.

Source files
------------

// File: rtl/mcash_axi3_mem_slave.sv
// AXI3 slave memory behind one mcash bank BIU port: a private array of 256-bit lines,
// one outstanding read and one outstanding write, each with a fixed response latency.
module mcash_axi3_mem_slave #(
    parameter int MEM_AW        = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRESP_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arvalid,
    output logic         arready,
    input  logic [7:0]   arid,
    input  logic [31:0]  araddr,
    input  logic [2:0]   arsize,
    input  logic [3:0]   arlen,
    input  logic [1:0]   arburst,
    output logic         rvalid,
    input  logic         rready,
    output logic [7:0]   rid,
    output logic [255:0] rdata,
    output logic [1:0]   rresp,
    output logic         rlast,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [3:0]   awlen,
    input  logic [2:0]   awsize,
    input  logic [1:0]   awburst,
    input  logic [7:0]   wid,
    input  logic         wvalid,
    output logic         wready,
    input  logic [255:0] wdata,
    input  logic [31:0]  wstrb,
    input  logic         wlast,
    output logic         bvalid,
    input  logic         bready,
    output logic [7:0]   bid,
    output logic [1:0]   bresp
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    logic [255:0] mem [0:DEPTH-1];

    r_state_t          r_state, r_state_d;
    logic [MEM_AW-1:0] r_line, r_idx;
    logic [1:0]        r_burst;
    logic [3:0]        r_len, r_len_d, r_beat, r_beat_d, r_lat, r_lat_d;
    logic              r_err, r_err_d, r_load;
    logic              arready_d, rvalid_d, rlast_d;
    logic [7:0]        rid_d;

    w_state_t          w_state, w_state_d;
    logic [MEM_AW-1:0] w_line, w_idx;
    logic [1:0]        w_burst;
    logic [3:0]        w_len, w_len_d, w_lat, w_lat_d;
    logic [7:0]        w_beat, w_beat_d, bid_d;
    logic              w_err, w_err_d, w_fire;
    logic              awready_d, wready_d, bvalid_d;
    logic [1:0]        bresp_d;

    // Only the line-index bits of the byte address select storage.
    logic unused_addr;
    assign unused_addr = ^{araddr[4:0], araddr[31:MEM_AW+5], awaddr[4:0], awaddr[31:MEM_AW+5]};

    always_comb begin
        r_state_d = r_state;
        r_len_d   = r_len;
        r_beat_d  = r_beat;
        r_lat_d   = r_lat;
        r_err_d   = r_err;
        r_load    = 1'b0;
        arready_d = arready;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rid_d     = rid;
        unique case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    rid_d     = arid;
                    r_len_d   = arlen;
                    r_err_d   = (arsize != 3'd5) || (arburst == 2'b11);
                    r_lat_d   = 4'(READ_LATENCY - 1);
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_lat == 4'd0) begin
                    r_beat_d  = 4'd0;
                    r_load    = 1'b1;
                    rvalid_d  = 1'b1;
                    rlast_d   = (r_len == 4'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_lat_d = r_lat - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_beat == r_len) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        // Next beat is registered on the accepting edge: no bubble.
                        r_beat_d = r_beat + 4'd1;
                        r_load   = 1'b1;
                        rlast_d  = (r_beat_d == r_len);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign r_idx = (r_burst == BURST_FIXED) ? r_line : r_line + MEM_AW'(r_beat_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_len   <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_err   <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_state_d;
            r_len   <= r_len_d;
            r_beat  <= r_beat_d;
            r_lat   <= r_lat_d;
            r_err   <= r_err_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rid     <= rid_d;
            if (r_load) begin
                // Array write below is non-blocking, so a same-edge write is not seen here.
                rdata <= r_err ? '0 : mem[r_idx];
                rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_comb begin
        w_state_d = w_state;
        w_len_d   = w_len;
        w_beat_d  = w_beat;
        w_lat_d   = w_lat;
        w_err_d   = w_err;
        awready_d = awready;
        wready_d  = wready;
        bvalid_d  = bvalid;
        bresp_d   = bresp;
        bid_d     = bid;
        unique case (w_state)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready) begin
                    w_len_d   = awlen;
                    w_beat_d  = 8'd0;
                    w_err_d   = (awsize != 3'd5);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    w_beat_d = w_beat + 8'd1;
                    if (w_beat == 8'd0) bid_d = wid;
                    else if (wid != bid) w_err_d = 1'b1;
                    if (wlast) begin
                        if (w_beat != {4'd0, w_len}) w_err_d = 1'b1;
                        wready_d  = 1'b0;
                        w_lat_d   = 4'(WRESP_LATENCY - 1);
                        w_state_d = W_WAIT;
                    end else if (w_beat >= {4'd0, w_len}) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            W_WAIT: begin
                if (w_lat == 4'd0) begin
                    bvalid_d  = 1'b1;
                    bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end else begin
                    w_lat_d = w_lat - 4'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign w_fire = (w_state == W_DATA) && wvalid && wready;
    assign w_idx  = (w_burst == BURST_FIXED) ? w_line : w_line + MEM_AW'(w_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_len   <= '0;
            w_beat  <= '0;
            w_lat   <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            bid     <= '0;
        end else begin
            w_state <= w_state_d;
            w_len   <= w_len_d;
            w_beat  <= w_beat_d;
            w_lat   <= w_lat_d;
            w_err   <= w_err_d;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            bresp   <= bresp_d;
            bid     <= bid_d;
        end
    end

    // Burst base line and type carry no reset; they are only used after a handshake.
    always_ff @(posedge clk) begin
        if (r_state == R_IDLE && arvalid && arready) begin
            r_line  <= araddr[MEM_AW+4:5];
            r_burst <= arburst;
        end
        if (w_state == W_IDLE && awvalid && awready) begin
            w_line  <= awaddr[MEM_AW+4:5];
            w_burst <= awburst;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < 32; i++) begin
                if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule
